// File: rtl/div_iterative.sv
// Radix-2 restoring divider: one quotient bit per clock, one operation in flight, valid/ready on both ends.
// Define DIV_SIGNED_EN for two's-complement operands (truncating division, remainder follows the dividend's sign).
module div_iterative #(
  parameter int W  = 24,
  parameter int CW = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         div_by_zero
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_work;
  logic [W-1:0]  r_dvsr;
  logic [W:0]    r_prem;
  logic          r_in_ready;
  logic          r_out_valid;
  logic          r_dbz;
  logic [W-1:0]  r_quot;
  logic [W-1:0]  r_rem;

  logic [W-1:0]  w_a_mag;
  logic [W-1:0]  w_b_mag;
  logic [W+1:0]  w_shift;
  logic [W+1:0]  w_diff;
  logic          w_ge;
  logic [W:0]    w_prem_nxt;
  logic [W-1:0]  w_work_nxt;
  logic          w_last;
  logic [W-1:0]  w_q_fin;
  logic [W-1:0]  w_r_fin;

  // The extra top bit of the shift keeps the trial subtraction's sign visible.
  assign w_shift    = {r_prem, r_work[W-1]};
  assign w_diff     = w_shift - {2'b00, r_dvsr};
  assign w_ge       = ~w_diff[W+1];
  assign w_prem_nxt = w_ge ? w_diff[W:0] : w_shift[W:0];
  assign w_work_nxt = {r_work[W-2:0], w_ge};
  assign w_last     = (r_cnt == CW'(W - 1));

`ifdef DIV_SIGNED_EN
  logic r_sign_q;
  logic r_sign_r;

  function automatic logic [W-1:0] f_neg_if(input logic [W-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  // The most-negative operand's magnitude still fits W unsigned bits.
  assign w_a_mag = f_neg_if(dividend, dividend[W-1]);
  assign w_b_mag = f_neg_if(divisor, divisor[W-1]);
  assign w_q_fin = r_dbz ? '1 : f_neg_if(w_work_nxt, r_sign_q);
  assign w_r_fin = f_neg_if(w_prem_nxt[W-1:0], r_sign_r);

  always_ff @(posedge clk) begin
    if (r_state == IDLE && in_valid) begin
      r_sign_q <= dividend[W-1] ^ divisor[W-1];
      r_sign_r <= dividend[W-1];
    end
  end
`else
  assign w_a_mag = dividend;
  assign w_b_mag = divisor;
  assign w_q_fin = w_work_nxt;
  assign w_r_fin = w_prem_nxt[W-1:0];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_quot      <= '0;
      r_rem       <= '0;
      r_dbz       <= 1'b0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_work     <= w_a_mag;
            r_dvsr     <= w_b_mag;
            r_prem     <= '0;
            r_dbz      <= (divisor == '0);
            r_cnt      <= '0;
            r_state    <= RUN;
            r_in_ready <= 1'b0;
          end
        end
        RUN: begin
          r_work <= w_work_nxt;
          r_prem <= w_prem_nxt;
          r_cnt  <= r_cnt + 1'b1;
          if (w_last) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
            r_quot      <= w_q_fin;
            r_rem       <= w_r_fin;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign quotient    = r_quot;
  assign remainder   = r_rem;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_div_iterative.sv
// Bench for div_iterative at W=8: vector table through a scoreboard, plus stall and mid-run reset sequences.
module tb_div_iterative;
  localparam int W  = 8;
  localparam int CW = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  always #5 clk = ~clk;

  div_iterative #(.W(W), .CW(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  function automatic vec_t mk(input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [W-1:0] q, input logic [W-1:0] r, input logic z);
    vec_t v;
    v.a = a; v.b = b; v.q = q; v.r = r; v.z = z;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  // Called just after a negedge; accept happens on the following posedge.
  task automatic issue(input vec_t v);
    in_valid = 1'b1;
    dividend = v.a;
    divisor  = v.b;
    chk("in_ready_at_issue", 32'(in_ready), 32'(1));
    @(posedge clk);
    sb.push_back(v);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 40);
    if (!out_valid) chk("out_valid_timeout", 32'(out_valid), 32'(1));
  endtask

  task automatic check_result(input string tag);
    vec_t e;
    if (sb.size() == 0) begin
      chk({tag, "_scoreboard_empty"}, 32'(sb.size()), 32'(1));
    end else begin
      e = sb.pop_front();
      chk({tag, "_quotient"}, 32'(quotient), 32'(e.q));
      chk({tag, "_remainder"}, 32'(remainder), 32'(e.r));
      chk({tag, "_div_by_zero"}, 32'(div_by_zero), 32'(e.z));
    end
  endtask

  initial begin
    int   lat;
    logic seen;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'(1));
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_quotient", 32'(quotient), 32'(0));
    chk("rst_remainder", 32'(remainder), 32'(0));
    chk("rst_div_by_zero", 32'(div_by_zero), 32'(0));

`ifdef DIV_SIGNED_EN
    tbl.push_back(mk(8'hF9, 8'h02, 8'hFD, 8'hFF, 1'b0));  // -7 / 2
    tbl.push_back(mk(8'h80, 8'hFF, 8'h80, 8'h00, 1'b0));  // -128 / -1
    tbl.push_back(mk(8'h07, 8'hFE, 8'hFD, 8'h01, 1'b0));  // 7 / -2
    tbl.push_back(mk(8'hF9, 8'hFE, 8'h03, 8'hFF, 1'b0));  // -7 / -2
    tbl.push_back(mk(8'd100, 8'd7, 8'd14, 8'd2, 1'b0));
    tbl.push_back(mk(8'h80, 8'h00, 8'hFF, 8'h80, 1'b1));  // -128 / 0
    tbl.push_back(mk(8'h05, 8'h00, 8'hFF, 8'h05, 1'b1));
    tbl.push_back(mk(8'h80, 8'h02, 8'hC0, 8'h00, 1'b0));  // -128 / 2
    tbl.push_back(mk(8'h80, 8'h01, 8'h80, 8'h00, 1'b0));
    tbl.push_back(mk(8'h03, 8'h07, 8'h00, 8'h03, 1'b0));
`else
    tbl.push_back(mk(8'd200, 8'd7, 8'd28, 8'd4, 1'b0));
    tbl.push_back(mk(8'd13, 8'd0, 8'd255, 8'd13, 1'b1));
    tbl.push_back(mk(8'd5, 8'd9, 8'd0, 8'd5, 1'b0));
    tbl.push_back(mk(8'd0, 8'd5, 8'd0, 8'd0, 1'b0));
    tbl.push_back(mk(8'd255, 8'd255, 8'd1, 8'd0, 1'b0));
    tbl.push_back(mk(8'd254, 8'd255, 8'd0, 8'd254, 1'b0));
    tbl.push_back(mk(8'd128, 8'd16, 8'd8, 8'd0, 1'b0));
    tbl.push_back(mk(8'd250, 8'd13, 8'd19, 8'd3, 1'b0));
    tbl.push_back(mk(8'd0, 8'd0, 8'd255, 8'd0, 1'b1));
    tbl.push_back(mk(8'd1, 8'd1, 8'd1, 8'd0, 1'b0));
`endif

    // Back-to-back operations with out_ready held high.
    foreach (tbl[i]) begin
      issue(tbl[i]);
      wait_result(lat);
      chk("latency", 32'(lat), 32'(W + 1));
      chk("in_ready_while_done", 32'(in_ready), 32'(0));
      check_result("vec");
      @(negedge clk);
      chk("out_valid_after_consume", 32'(out_valid), 32'(0));
      chk("in_ready_after_consume", 32'(in_ready), 32'(1));
    end

    // Stall: result must hold and in_valid must be ignored.
    out_ready = 1'b0;
    issue(mk(8'hFF, 8'h01, 8'hFF, 8'h00, 1'b0));
    wait_result(lat);
    check_result("stall");
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      dividend = 8'h03;
      divisor  = 8'h02;
      @(negedge clk);
      chk("stall_out_valid", 32'(out_valid), 32'(1));
      chk("stall_in_ready", 32'(in_ready), 32'(0));
      chk("stall_quotient", 32'(quotient), 32'(8'hFF));
      chk("stall_remainder", 32'(remainder), 32'(0));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("stall_release_out_valid", 32'(out_valid), 32'(0));
    chk("stall_release_in_ready", 32'(in_ready), 32'(1));
    @(negedge clk);
    chk("stall_no_spurious_accept", 32'(in_ready), 32'(1));

    // Reset on the 4th RUN edge discards the operation.
    issue(mk(8'd100, 8'd3, 8'd33, 8'd1, 1'b0));
    void'(sb.pop_back());
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrun_rst_in_ready", 32'(in_ready), 32'(1));
    chk("midrun_rst_out_valid", 32'(out_valid), 32'(0));
    chk("midrun_rst_quotient", 32'(quotient), 32'(0));
    chk("midrun_rst_remainder", 32'(remainder), 32'(0));
    seen = 1'b0;
    repeat (W + 3) begin
      @(negedge clk);
      seen = seen | out_valid;
    end
    chk("midrun_rst_no_result", 32'(seen), 32'(0));
    issue(mk(8'd100, 8'd3, 8'd33, 8'd1, 1'b0));
    wait_result(lat);
    chk("after_rst_latency", 32'(lat), 32'(W + 1));
    check_result("after_rst");
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
